// File: rtl/hazard_io_pkg.sv
// hazard_io: shared types and helpers for the pipeline hazard interface
package hazard_io;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} hazard_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hardwired zero, so it never creates a dependency
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: operand source select for one Execute operand, MEM over WB
module hazard_fwd_sel
    import hazard_io::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb
        fwd = (reg_write_m && reg_hit(rd_m, rs)) ? FWD_MEM :
              (reg_write_w && reg_hit(rd_w, rs)) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control, debug halt drain FSM and
// bring-up event counters for the 5-stage RV32 pipeline
module hazard_ctrl
    import hazard_io::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 ResultSrcE_zero,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 halt_req,
    input  logic                 cnt_clr,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 halt_ack,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hazard_state_t state, state_next;
    logic [DW-1:0] drain_cnt, drain_next;
    logic          lw_stall;
    logic [1:0]    fwd_a, fwd_b;

    hazard_fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign lw_stall = ResultSrcE_zero && (reg_hit(RdE, Rs1D) || reg_hit(RdE, Rs2D));

    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        halt_ack   = 1'b0;
        ForwardAE  = fwd_a;
        ForwardBE  = fwd_b;
        unique case (state)
            RUN: begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
                if (halt_req) begin
                    state_next = DRAIN;
                    drain_next = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                // a branch resolving mid-drain must still land its target in the PC
                StallF     = !PCSrcE;
                StallD     = 1'b1;
                FlushD     = PCSrcE;
                FlushE     = 1'b1;
                drain_next = drain_cnt - 1'b1;
                if (drain_cnt == '0) state_next = HALTED;
            end
            HALTED: begin
                StallF   = 1'b1;
                StallD   = 1'b1;
                FlushE   = 1'b1;
                halt_ack = 1'b1;
                if (!halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (reset) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            halt_ack  = 1'b0;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN && lw_stall) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (PCSrcE) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random stimulus against a timeline-based
// reference model of the hazard controller
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int DC   = 3;
    localparam int MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, halt_req, cnt_clr;
    logic          StallF, StallD, FlushD, FlushE, halt_ack;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int drain_start = -1;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE_zero(ResultSrcE_zero), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .halt_req(halt_req), .cnt_clr(cnt_clr),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .halt_ack(halt_ack),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int fwd_ref(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    task automatic idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, cnt_clr} = '0;
    endtask

    // halt timeline: drain occupies cycles drain_start..drain_start+DC-1, halted after
    task automatic tick();
        bit dr, ht, lw, pc;
        int sf, sd, fd, fe, ack, fa, fb;
        #1;
        dr = drain_start >= 0 && cyc < drain_start + DC;
        ht = drain_start >= 0 && cyc >= drain_start + DC;
        lw = ResultSrcE_zero && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        pc = PCSrcE;
        fa = fwd_ref(Rs1E);
        fb = fwd_ref(Rs2E);
        if (ht) begin
            sf = 1; sd = 1; fd = 0; fe = 1; ack = 1;
        end else if (dr) begin
            sf = !pc; sd = 1; fd = pc; fe = 1; ack = 0;
        end else begin
            sf = lw; sd = lw; fd = pc; fe = lw || pc; ack = 0;
        end
        if (reset) begin
            sf = 0; sd = 0; fd = 0; fe = 0; ack = 0; fa = 0; fb = 0;
        end
        chk("StallF", 32'(StallF), 32'(sf));
        chk("StallD", 32'(StallD), 32'(sd));
        chk("FlushD", 32'(FlushD), 32'(fd));
        chk("FlushE", 32'(FlushE), 32'(fe));
        chk("halt_ack", 32'(halt_ack), 32'(ack));
        chk("ForwardAE", 32'(ForwardAE), 32'(fa));
        chk("ForwardBE", 32'(ForwardBE), 32'(fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        if (reset) begin
            m_stall = 0;
            m_flush = 0;
            drain_start = -1;
        end else begin
            if (cnt_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (!dr && !ht && lw) m_stall = (m_stall + 1) & MASK;
                if (pc) m_flush = (m_flush + 1) & MASK;
            end
            if (!dr && !ht && halt_req) drain_start = cyc + 1;
            else if (ht && !halt_req) drain_start = -1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic load_use();
        idle();
        ResultSrcE_zero = 1'b1;
        RdE = 5'd7;
        Rs2D = 5'd7;
    endtask

    initial begin
        reset = 1'b1;
        halt_req = 1'b0;
        idle();
        @(posedge clk);
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();
        // forwarding priority and x0
        RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; Rs2E = 5;
        tick();
        RdM = 0; Rs1E = 0;
        tick();
        // load-use, then a load to x0
        load_use();
        tick();
        idle();
        tick();
        ResultSrcE_zero = 1; RdE = 0; Rs1D = 0;
        tick();
        // taken branch alone and with a load-use
        idle();
        PCSrcE = 1;
        tick();
        load_use();
        PCSrcE = 1;
        tick();
        idle();
        tick();
        // sustained halt with a branch mid-drain
        halt_req = 1;
        tick();
        tick();
        PCSrcE = 1;
        tick();
        PCSrcE = 0;
        repeat (4) tick();
        halt_req = 0;
        repeat (2) tick();
        // one-cycle pulse
        halt_req = 1;
        tick();
        halt_req = 0;
        repeat (6) tick();
        // reset in the middle of a drain
        halt_req = 1;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        halt_req = 0;
        repeat (2) tick();
        // counter wrap and clear priority
        load_use();
        repeat (18) tick();
        cnt_clr = 1;
        tick();
        idle();
        tick();
        repeat (2000) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));
            RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            ResultSrcE_zero = ($urandom_range(0, 2) == 0);
            RegWriteM = $urandom_range(0, 1) == 1;
            RegWriteW = $urandom_range(0, 1) == 1;
            PCSrcE = ($urandom_range(0, 4) == 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) halt_req = !halt_req;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
